// File: rtl/vga_pkg.sv
// Shared state encoding and default frame-buffer geometry for the VGA frame-buffer arbiter.
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2
    } fb_state_t;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;

endpackage

// File: rtl/vga_pf_fifo.sv
// Synchronous prefetch FIFO (DEPTH x DATA_W, DEPTH a power of 2) with flush and occupancy count.
module vga_pf_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_do_push = i_push && !i_flush && ((r_count != C_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    // Head is masked while empty so a stale entry never shows on pix_data.
    assign o_rdata = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display prefetch vs. pixel writer, with prefetch FIFO.
// Optional sticky underrun detection is built only when FB_ARB_UNDERRUN_EN is defined.
//
// state      | meaning
// WAIT_FRAME | no frame active; writer owns the RAM every cycle
// RUN        | fetching pixels 0..FB_SIZE-1 into the FIFO, writer gets spare slots
// DONE       | whole frame fetched; writer owns the RAM until the next frame_start
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int FB_SIZE  = FB_PIXELS,
    parameter int PF_DEPTH = 4,
    parameter int LOW_WM   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_avail,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underrun
);

    localparam int CW = $clog2(PF_DEPTH) + 1;
    localparam logic [CW:0]       C_LOW_WM = (CW+1)'(LOW_WM);
    localparam logic [CW:0]       C_DEPTH  = (CW+1)'(PF_DEPTH);
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(FB_SIZE - 1);

    fb_state_t         r_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_rd_pend;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_level;
    logic              w_fetch;
    logic              w_wgrant;
    logic              w_write;
    logic              w_empty;
    logic              w_push;

    assign w_level = (CW+1)'(w_count) + (CW+1)'(r_rd_pend);

    always_comb begin
        w_fetch  = 1'b0;
        w_wgrant = 1'b0;
        if (reset) begin
            case (r_state)
                RUN: begin
                    if (w_level <= C_LOW_WM)  w_fetch  = 1'b1;
                    else if (wr_valid)        w_wgrant = 1'b1;
                    else if (w_level < C_DEPTH) w_fetch = 1'b1;
                end
                default: w_wgrant = 1'b1;
            endcase
            // A fetch launched alongside frame_start would return into the flushed FIFO.
            if (frame_start) w_fetch = 1'b0;
        end
    end

    assign w_write   = w_wgrant && wr_valid;
    assign wr_ready  = w_wgrant;
    assign mem_en    = w_fetch || w_write;
    assign mem_we    = w_write;
    assign mem_addr  = w_write ? wr_addr : (w_fetch ? r_fetch_addr : '0);
    assign mem_wdata = w_write ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= WAIT_FRAME;
            r_fetch_addr <= '0;
            r_rd_pend    <= 1'b0;
        end else if (frame_start) begin
            r_state      <= RUN;
            r_fetch_addr <= '0;
            r_rd_pend    <= 1'b0;
        end else begin
            r_rd_pend <= w_fetch;
            if (w_fetch) begin
                r_fetch_addr <= r_fetch_addr + 1'b1;
                if (r_fetch_addr == C_LAST) r_state <= DONE;
            end
        end
    end

    assign w_push = r_rd_pend && !frame_start;

    vga_pf_fifo #(
        .DEPTH  (PF_DEPTH),
        .DATA_W (DATA_W)
    ) u_pf_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (frame_start),
        .i_push  (w_push),
        .i_pop   (pix_rd),
        .i_wdata (mem_rdata),
        .o_rdata (pix_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign pix_avail = !w_empty;

`ifdef FB_ARB_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk) begin
        if (!reset)                   r_underrun <= 1'b0;
        else if (pix_rd && w_empty)   r_underrun <= 1'b1;
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model, fetch/pixel scoreboard, writer and frame-control steps.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 12;
    localparam int FB_SIZE  = 76800;
    localparam int PF_DEPTH = 4;
`ifdef FB_ARB_UNDERRUN_EN
    localparam logic U_EXP = 1'b1;
`else
    localparam logic U_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              pix_rd;
    logic [DATA_W-1:0] pix_data;
    logic              pix_avail;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              underrun;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int exp_addr = 0;
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] wmem [int];

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_avail   (pix_avail),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .underrun    (underrun)
    );

    function automatic logic [DATA_W-1:0] pat(input int a);
        int v;
        v = a * 37 + 5;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ram_val(input int a);
        if (wmem.exists(a)) return wmem[a];
        return pat(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
            else        mem_rdata <= ram_val(int'(mem_addr));
        end
    end

    // Scoreboard: push expected pixel per fetch, compare on every accepted pop.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_start) begin
                sb_q.delete();
                exp_addr = 0;
            end else begin
                if (mem_en && !mem_we) begin
                    check("fetch_addr", 32'(mem_addr), 32'(exp_addr));
                    check("fetch_past_end", 32'(exp_addr < FB_SIZE), 32'd1);
                    check("fetch_level", 32'(sb_q.size() < PF_DEPTH), 32'd1);
                    sb_q.push_back(ram_val(exp_addr));
                    exp_addr++;
                end
                if (pix_rd && pix_avail) begin
                    n_pop++;
                    if (sb_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                    else                  check("pix_data", 32'(pix_data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int pops0;
        bit hit;
        reset = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
        wr_valid = 1'b1; wr_addr = 17'h00050; wr_data = 12'hABC;

        // reset held two cycles with a writer request pending
        repeat (2) @(negedge clk);
        check("rst_pix_avail", 32'(pix_avail), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(WAIT_FRAME));

        step(); reset = 1'b1;
        @(negedge clk);
        check("wait_wr_ready", 32'(wr_ready), 32'd1);
        check("wait_mem_we", 32'(mem_we), 32'd1);
        check("wait_mem_addr", 32'(mem_addr), 32'h050);
        check("wait_mem_wdata", 32'(mem_wdata), 32'hABC);
        step(); wr_valid = 1'b0;
        check("ram_0x050", 32'(ram_val(32'h050)), 32'hABC);

        // pix_rd with nothing buffered
        pix_rd = 1'b1;
        step(); pix_rd = 1'b0;
        @(negedge clk);
        check("underrun_set", 32'(underrun), 32'(U_EXP));
        repeat (3) @(negedge clk);
        check("underrun_hold", 32'(underrun), 32'(U_EXP));

        // frame with display reading every 4th cycle, no writer
        step(); frame_start = 1'b1;
        step(); frame_start = 1'b0;
        pops0 = n_pop;
        for (int i = 0; i < 24; i++) begin
            pix_rd = ((i % 4) == 3);
            step();
        end
        pix_rd = 1'b0;
        check("slow_pop_count", 32'(n_pop - pops0), 32'd6);
        repeat (8) step();
        @(negedge clk);
        check("full_idle", 32'(mem_en), 32'd0);
        check("full_avail", 32'(pix_avail), 32'd1);

        // level 4 -> pop to 3, writer wins; drain to 1, fetch wins
        step(); pix_rd = 1'b1;
        @(negedge clk);
        check("lvl4_idle", 32'(mem_en), 32'd0);
        step(); pix_rd = 1'b0; wr_valid = 1'b1; wr_addr = 17'h00100; wr_data = 12'hF00;
        @(negedge clk);
        check("lvl3_wr_ready", 32'(wr_ready), 32'd1);
        check("lvl3_mem_we", 32'(mem_we), 32'd1);
        check("lvl3_mem_addr", 32'(mem_addr), 32'h100);
        check("lvl3_mem_wdata", 32'(mem_wdata), 32'hF00);
        step(); pix_rd = 1'b1;
        check("ram_0x100", 32'(ram_val(32'h100)), 32'hF00);
        @(negedge clk);
        check("lvl3b_wr_ready", 32'(wr_ready), 32'd1);
        step();
        @(negedge clk);
        check("lvl2_wr_ready", 32'(wr_ready), 32'd1);
        step(); pix_rd = 1'b0;
        @(negedge clk);
        check("lvl1_wr_ready", 32'(wr_ready), 32'd0);
        check("lvl1_fetch_en", 32'(mem_en), 32'd1);
        check("lvl1_fetch_we", 32'(mem_we), 32'd0);
        step(); wr_valid = 1'b0; pix_rd = 1'b1;

        // restart mid-frame while the fetch of address 500 is in flight
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 17'd500) hit = 1'b1;
        end
        check("reach_addr500", 32'(hit), 32'd1);
        step(); frame_start = 1'b1; pix_rd = 1'b0;
        check("restart_in_flight", 32'(dut.r_rd_pend), 32'd1);
        @(negedge clk);
        check("restart_no_fetch", 32'(mem_en), 32'd0);
        step(); frame_start = 1'b0;
        @(negedge clk);
        check("restart_fifo_empty", 32'(pix_avail), 32'd0);
        check("restart_fetch_en", 32'(mem_en && !mem_we), 32'd1);
        check("restart_fetch_addr", 32'(mem_addr), 32'd0);
        step(); pix_rd = 1'b1;

        // run the full frame out to the last pixel
        hit = 1'b0;
        for (int i = 0; i < 80000 && !hit; i++) begin
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 17'(FB_SIZE - 1)) hit = 1'b1;
        end
        check("reach_last_addr", 32'(hit), 32'd1);
        step();
        @(negedge clk);
        check("done_state", 32'(dut.r_state), 32'(DONE));
        check("done_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            wr_valid = i[0];
            wr_addr = 17'h00200 + 17'(i);
            wr_data = 12'(i);
            @(negedge clk);
            check("done_wr_ready_hold", 32'(wr_ready), 32'd1);
            check("done_mem_en", 32'(mem_en), 32'(wr_valid));
        end
        step(); wr_valid = 1'b0; pix_rd = 1'b0;
        repeat (2) step();
        check("final_underrun", 32'(underrun), 32'(U_EXP));
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
